// File: rtl/wb_com_pkg.sv
// Shared definitions for the wb_com master/slave ports: header layout, ID encoding, width helpers.
// Latency: n/a (types, constants and constant functions only).
// Backpressure: n/a.
//
// Header layout, MSB to LSB: {addr, sel, we, tag}.
package wb_com_pkg;

   // Source ID carried through the outstanding queue.
   typedef enum logic {
      ID_M0 = 1'b0,
      ID_M1 = 1'b1
   } wb_id_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } wb_slv_state_e;

   function automatic int wb_sel_width(input int data_w);
      return data_w / 8;
   endfunction

   function automatic int wb_hdr_width(input int addr_w, input int data_w, input int tag_w);
      return addr_w + wb_sel_width(data_w) + 1 + tag_w;
   endfunction

   // Field LSB offsets inside the header word.
   function automatic int hdr_tag_lsb();
      return 0;
   endfunction

   function automatic int hdr_we_lsb(input int tag_w);
      return tag_w;
   endfunction

   function automatic int hdr_sel_lsb(input int tag_w);
      return tag_w + 1;
   endfunction

   function automatic int hdr_addr_lsb(input int tag_w, input int sel_w);
      return tag_w + 1 + sel_w;
   endfunction

endpackage

// File: rtl/wb_com_fifo.sv
// Small synchronous show-ahead FIFO of 2**ASIZE entries; head word visible while empty is low.
// Latency: push to empty-deasserted is 1 cycle; pop takes effect at the next edge.
// Backpressure: full flag only; pushing while full is dropped and flagged by an assertion.
//
// Ports: clk/rst_n; push_vld/push_dat write side; pop_vld read side; head_dat, empty, full status.
module wb_com_fifo #(
   parameter int WIDTH = 32,
   parameter int ASIZE = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_vld,
   input  logic [WIDTH-1:0] push_dat,
   input  logic             pop_vld,
   output logic [WIDTH-1:0] head_dat,
   output logic             empty,
   output logic             full
);

   localparam int DEPTH = 1 << ASIZE;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [ASIZE:0]   wr_ptr;
   logic [ASIZE:0]   rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_push  = push_vld && !full;
   assign do_pop   = pop_vld && !empty;
   assign empty    = (wr_ptr == rd_ptr);
   // Extra pointer bit distinguishes full from empty when the index bits match.
   assign full     = (wr_ptr[ASIZE] != rd_ptr[ASIZE]) &&
                     (wr_ptr[ASIZE-1:0] == rd_ptr[ASIZE-1:0]);
   assign head_dat = mem[rd_ptr[ASIZE-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + (ASIZE+1)'(1);
         if (do_pop)  rd_ptr <= rd_ptr + (ASIZE+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[ASIZE-1:0]] <= push_dat;
   end

   // The owner's credit scheme must make this unreachable.
   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push_vld && full));

endmodule

// File: rtl/wb_com_slave.sv
// Slave port of the wb_com crossbar: arbitrates two master header FIFOs onto one pipelined Wishbone bus.
// Latency: header pop to stb 1 cycle; ack/err to response visible 1 cycle.
// Backpressure: stall freezes the request register; per-master credits and outstanding-queue room gate pops.
//
// Ports: clk, rst_n; mK_to_s_header_o/hempty/hrden and mK_to_s_data_o/drden request side (K=0,1);
//        s_to_mK_data_o/drden/dempty response side; s_wb_* slave Wishbone bus.
module wb_com_slave
   import wb_com_pkg::*;
#(
   parameter int WB_ADDR_WIDTH = 32,
   parameter int WB_DATA_WIDTH = 32,
   parameter int WB_TIME_TAG   = 4,
   parameter int WB_FIFO_ASIZE = WB_TIME_TAG - 2,
   parameter int WB_SEL_WIDTH  = wb_sel_width(WB_DATA_WIDTH),
   parameter int WB_HDR_WIDTH  = wb_hdr_width(WB_ADDR_WIDTH, WB_DATA_WIDTH, WB_TIME_TAG)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [WB_HDR_WIDTH-1:0]  m0_to_s_header_o,
   input  logic                     m0_to_s_hempty,
   output logic                     m0_to_s_hrden,
   input  logic [WB_DATA_WIDTH-1:0] m0_to_s_data_o,
   output logic                     m0_to_s_drden,
   input  logic [WB_HDR_WIDTH-1:0]  m1_to_s_header_o,
   input  logic                     m1_to_s_hempty,
   output logic                     m1_to_s_hrden,
   input  logic [WB_DATA_WIDTH-1:0] m1_to_s_data_o,
   output logic                     m1_to_s_drden,
   output logic [WB_DATA_WIDTH-1:0] s_to_m0_data_o,
   input  logic                     s_to_m0_drden,
   output logic                     s_to_m0_dempty,
   output logic [WB_DATA_WIDTH-1:0] s_to_m1_data_o,
   input  logic                     s_to_m1_drden,
   output logic                     s_to_m1_dempty,
   output logic [WB_ADDR_WIDTH-1:0] s_wb_addr_i,
   output logic [WB_DATA_WIDTH-1:0] s_wb_dat_i,
   output logic [WB_SEL_WIDTH-1:0]  s_wb_sel_i,
   output logic                     s_wb_cyc_i,
   output logic                     s_wb_stb_i,
   output logic                     s_wb_we_i,
   input  logic [WB_DATA_WIDTH-1:0] s_wb_dat_o,
   input  logic                     s_wb_ack_o,
   input  logic                     s_wb_err_o,
   input  logic                     s_wb_stall_o
);

   localparam int TAG_LSB  = hdr_tag_lsb();
   localparam int WE_LSB   = hdr_we_lsb(WB_TIME_TAG);
   localparam int SEL_LSB  = hdr_sel_lsb(WB_TIME_TAG);
   localparam int ADDR_LSB = hdr_addr_lsb(WB_TIME_TAG, WB_SEL_WIDTH);
   localparam int OQ_AW    = WB_TIME_TAG - 1;
   localparam int OQ_DEPTH = 1 << OQ_AW;
   localparam int CRED_W   = WB_FIFO_ASIZE + 1;
   localparam logic [CRED_W-1:0] CRED_INIT = CRED_W'(1 << WB_FIFO_ASIZE);

   function automatic logic [CRED_W-1:0] cred_next(input logic [CRED_W-1:0] cur,
                                                   input logic take, input logic give);
      logic [CRED_W-1:0] nxt;
      nxt = cur;
      if (take && !give) nxt = cur - CRED_W'(1);
      if (give && !take) nxt = cur + CRED_W'(1);
      return nxt;
   endfunction

   // Request register and control state
   logic [WB_ADDR_WIDTH-1:0] req_addr;
   logic [WB_DATA_WIDTH-1:0] req_dat;
   logic [WB_SEL_WIDTH-1:0]  req_sel;
   logic                     req_we;
   logic                     req_stb;
   wb_id_e                   req_id;
   logic                     run_en;
   logic [CRED_W-1:0]        cred0;
   logic [CRED_W-1:0]        cred1;
   wb_slv_state_e            state;
   wb_slv_state_e            state_nxt;

   // Outstanding queue (in-order source IDs)
   wb_id_e                   oq_mem [OQ_DEPTH];
   logic [OQ_AW-1:0]         oq_wr;
   logic [OQ_AW-1:0]         oq_rd;
   logic [OQ_AW:0]           oq_cnt;
   logic [OQ_AW+1:0]         oq_occ;

   logic [WB_TIME_TAG-1:0]   tag_diff;
   logic                     m1_older;
   logic                     elig0, elig1, pick1;
   logic                     accept, slot_ok, oq_room, can_pop;
   logic                     pop0, pop1, pop_any;
   logic [WB_HDR_WIDTH-1:0]  hdr_sel;
   logic [WB_DATA_WIDTH-1:0] wdat_sel;
   logic                     rsp_vld;
   wb_id_e                   rsp_id;
   logic [WB_DATA_WIDTH-1:0] rsp_dat;
   logic                     ret0, ret1;

   // m1 is older when (tag0 - tag1) mod 2^T lies in [1, 2^(T-1)); ties favour m0.
   assign tag_diff = m0_to_s_header_o[TAG_LSB +: WB_TIME_TAG] - m1_to_s_header_o[TAG_LSB +: WB_TIME_TAG];
   assign m1_older = (tag_diff != '0) && !tag_diff[WB_TIME_TAG-1];

   assign elig0   = !m0_to_s_hempty && (cred0 != '0);
   assign elig1   = !m1_to_s_hempty && (cred1 != '0);
   assign pick1   = elig1 && (!elig0 || m1_older);

   assign accept  = req_stb && !s_wb_stall_o;
   assign slot_ok = !req_stb || !s_wb_stall_o;
   // The request register counts as a reserved queue slot so the queue can never overflow on accept.
   assign oq_occ  = {1'b0, oq_cnt} + {{(OQ_AW+1){1'b0}}, accept};
   assign oq_room = oq_occ < (OQ_AW+2)'(OQ_DEPTH);
   assign can_pop = run_en && slot_ok && oq_room;

   assign pop1    = can_pop && pick1;
   assign pop0    = can_pop && elig0 && !pick1;
   assign pop_any = pop0 || pop1;

   assign m0_to_s_hrden = pop0;
   assign m1_to_s_hrden = pop1;
   assign m0_to_s_drden = pop0 && m0_to_s_header_o[WE_LSB];
   assign m1_to_s_drden = pop1 && m1_to_s_header_o[WE_LSB];

   assign hdr_sel  = pop1 ? m1_to_s_header_o : m0_to_s_header_o;
   assign wdat_sel = pop1 ? m1_to_s_data_o   : m0_to_s_data_o;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_addr <= '0;
         req_dat  <= '0;
         req_sel  <= '0;
         req_we   <= 1'b0;
         req_stb  <= 1'b0;
         req_id   <= ID_M0;
         run_en   <= 1'b0;
      end else begin
         // Pops are held off for the first cycle out of reset.
         run_en <= 1'b1;
         if (pop_any) begin
            req_addr <= hdr_sel[ADDR_LSB +: WB_ADDR_WIDTH];
            req_sel  <= hdr_sel[SEL_LSB +: WB_SEL_WIDTH];
            req_we   <= hdr_sel[WE_LSB];
            req_dat  <= hdr_sel[WE_LSB] ? wdat_sel : '0;
            req_id   <= pop1 ? ID_M1 : ID_M0;
            req_stb  <= 1'b1;
         end else if (accept) begin
            req_stb  <= 1'b0;
         end
      end
   end

   // Responses: ack/err with nothing outstanding is dropped.
   assign rsp_vld = (s_wb_ack_o || s_wb_err_o) && (oq_cnt != '0);
   assign rsp_id  = oq_mem[oq_rd];
   assign rsp_dat = s_wb_err_o ? '0 : s_wb_dat_o;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         oq_wr  <= '0;
         oq_rd  <= '0;
         oq_cnt <= '0;
      end else begin
         if (accept)  oq_wr <= oq_wr + OQ_AW'(1);
         if (rsp_vld) oq_rd <= oq_rd + OQ_AW'(1);
         if (accept && !rsp_vld) oq_cnt <= oq_cnt + (OQ_AW+1)'(1);
         if (rsp_vld && !accept) oq_cnt <= oq_cnt - (OQ_AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (accept) oq_mem[oq_wr] <= req_id;
   end

   // A credit returns only when a response word actually leaves the FIFO.
   assign ret0 = s_to_m0_drden && !s_to_m0_dempty;
   assign ret1 = s_to_m1_drden && !s_to_m1_dempty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cred0 <= CRED_INIT;
         cred1 <= CRED_INIT;
      end else begin
         cred0 <= cred_next(cred0, pop0, ret0);
         cred1 <= cred_next(cred1, pop1, ret1);
      end
   end

   // Bus cycle FSM: cyc rises together with the first stb and falls once nothing is pending.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (pop_any) state_nxt = ST_BUSY;
         ST_BUSY: if (!pop_any && !req_stb &&
                      ((oq_cnt == '0) || ((oq_cnt == (OQ_AW+1)'(1)) && rsp_vld)))
                     state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign s_wb_cyc_i  = (state == ST_BUSY);
   assign s_wb_stb_i  = req_stb;
   assign s_wb_addr_i = req_addr;
   assign s_wb_dat_i  = req_dat;
   assign s_wb_sel_i  = req_sel;
   assign s_wb_we_i   = req_we;

   wb_com_fifo #(.WIDTH(WB_DATA_WIDTH), .ASIZE(WB_FIFO_ASIZE)) u_rsp_fifo0 (
      .clk      (clk),
      .rst_n    (rst_n),
      .push_vld (rsp_vld && (rsp_id == ID_M0)),
      .push_dat (rsp_dat),
      .pop_vld  (s_to_m0_drden),
      .head_dat (s_to_m0_data_o),
      .empty    (s_to_m0_dempty),
      .full     ()
   );

   wb_com_fifo #(.WIDTH(WB_DATA_WIDTH), .ASIZE(WB_FIFO_ASIZE)) u_rsp_fifo1 (
      .clk      (clk),
      .rst_n    (rst_n),
      .push_vld (rsp_vld && (rsp_id == ID_M1)),
      .push_dat (rsp_dat),
      .pop_vld  (s_to_m1_drden),
      .head_dat (s_to_m1_data_o),
      .empty    (s_to_m1_dempty),
      .full     ()
   );

endmodule

// File: tb/tb_wb_com_slave.sv
// Testbench for wb_com_slave: header-FIFO masters, scripted Wishbone slave, transaction-level reference model.
// Latency: n/a.
// Backpressure: stall and response pops are driven by the directed sequences.
module tb_wb_com_slave;

   localparam int HW = 41;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [HW-1:0] m0_to_s_header_o, m1_to_s_header_o;
   logic          m0_to_s_hempty, m1_to_s_hempty;
   logic          m0_to_s_hrden, m1_to_s_hrden, m0_to_s_drden, m1_to_s_drden;
   logic [31:0]   m0_to_s_data_o, m1_to_s_data_o;
   logic [31:0]   s_to_m0_data_o, s_to_m1_data_o;
   logic          s_to_m0_drden, s_to_m1_drden, s_to_m0_dempty, s_to_m1_dempty;
   logic [31:0]   s_wb_addr_i, s_wb_dat_i, s_wb_dat_o;
   logic [3:0]    s_wb_sel_i;
   logic          s_wb_cyc_i, s_wb_stb_i, s_wb_we_i;
   logic          s_wb_ack_o, s_wb_err_o, s_wb_stall_o;

   always #5 clk = ~clk;

   wb_com_slave dut (
      .clk(clk), .rst_n(rst_n),
      .m0_to_s_header_o(m0_to_s_header_o), .m0_to_s_hempty(m0_to_s_hempty), .m0_to_s_hrden(m0_to_s_hrden),
      .m0_to_s_data_o(m0_to_s_data_o), .m0_to_s_drden(m0_to_s_drden),
      .m1_to_s_header_o(m1_to_s_header_o), .m1_to_s_hempty(m1_to_s_hempty), .m1_to_s_hrden(m1_to_s_hrden),
      .m1_to_s_data_o(m1_to_s_data_o), .m1_to_s_drden(m1_to_s_drden),
      .s_to_m0_data_o(s_to_m0_data_o), .s_to_m0_drden(s_to_m0_drden), .s_to_m0_dempty(s_to_m0_dempty),
      .s_to_m1_data_o(s_to_m1_data_o), .s_to_m1_drden(s_to_m1_drden), .s_to_m1_dempty(s_to_m1_dempty),
      .s_wb_addr_i(s_wb_addr_i), .s_wb_dat_i(s_wb_dat_i), .s_wb_sel_i(s_wb_sel_i),
      .s_wb_cyc_i(s_wb_cyc_i), .s_wb_stb_i(s_wb_stb_i), .s_wb_we_i(s_wb_we_i),
      .s_wb_dat_o(s_wb_dat_o), .s_wb_ack_o(s_wb_ack_o), .s_wb_err_o(s_wb_err_o), .s_wb_stall_o(s_wb_stall_o)
   );

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  sel;
      logic        we;
      logic [3:0]  tag;
      logic [31:0] data;
   } hreq_t;

   typedef struct {
      int          id;
      logic [31:0] addr;
   } acc_t;

   // Reference model state
   hreq_t       hq0[$], hq1[$];   // master header FIFOs
   logic [31:0] rq0[$], rq1[$];   // expected response FIFO contents
   int          oq[$];            // outstanding source IDs, oldest first
   acc_t        acc_log[$];       // accepted requests in bus order
   int          cred0, cred1;
   bit          pend;             // a request is presented on the bus
   hreq_t       preq;
   int          pid;
   int          cyc_no, pop_cyc, acc_cyc;

   // Snapshot of DUT outputs taken mid-cycle
   logic        s_cyc, s_stb, s_we, s_hr0, s_hr1, s_de0, s_de1;
   logic [31:0] s_addr, s_dat, s_d0, s_d1;
   logic [3:0]  s_sel;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc_no);
      end
   endtask

   // m1 wins when (tag0 - tag1) mod 16 is in 1..7.
   function automatic logic m1_is_older(input logic [3:0] t0, input logic [3:0] t1);
      int d;
      d = (int'(t0) - int'(t1) + 16) % 16;
      return (d != 0) && (d < 8);
   endfunction

   function automatic logic [HW-1:0] pack_hdr(input hreq_t h);
      return {h.addr, h.sel, h.we, h.tag};
   endfunction

   function automatic int acc_id(input int k);
      return (k < acc_log.size()) ? acc_log[k].id : -1;
   endfunction

   function automatic logic [31:0] acc_addr(input int k);
      return (k < acc_log.size()) ? acc_log[k].addr : 32'hFFFF_FFFF;
   endfunction

   task automatic drive_hdr();
      m0_to_s_hempty   = (hq0.size() == 0);
      m0_to_s_header_o = (hq0.size() != 0) ? pack_hdr(hq0[0]) : '0;
      m0_to_s_data_o   = (hq0.size() != 0) ? hq0[0].data : '0;
      m1_to_s_hempty   = (hq1.size() == 0);
      m1_to_s_header_o = (hq1.size() != 0) ? pack_hdr(hq1[0]) : '0;
      m1_to_s_data_o   = (hq1.size() != 0) ? hq1[0].data : '0;
   endtask

   task automatic push_hdr(input int k, input logic [31:0] addr, input logic [3:0] sel,
                           input logic we, input logic [3:0] tag, input logic [31:0] data);
      hreq_t h;
      h.addr = addr; h.sel = sel; h.we = we; h.tag = tag; h.data = data;
      if (k == 1) hq1.push_back(h);
      else        hq0.push_back(h);
      drive_hdr();
   endtask

   task automatic model_reset();
      rq0.delete(); rq1.delete(); oq.delete();
      cred0 = 4; cred1 = 4;
      pend  = 1'b0;
   endtask

   // One clock cycle: compare at the falling edge, advance the model, then drive after the rising edge.
   task automatic cycle();
      hreq_t       h;
      int          id;
      logic [31:0] v;
      @(negedge clk);
      cyc_no++;
      s_cyc = s_wb_cyc_i;    s_stb = s_wb_stb_i;    s_we  = s_wb_we_i;
      s_addr = s_wb_addr_i;  s_sel = s_wb_sel_i;    s_dat = s_wb_dat_i;
      s_hr0 = m0_to_s_hrden; s_hr1 = m1_to_s_hrden;
      s_de0 = s_to_m0_dempty; s_de1 = s_to_m1_dempty;
      s_d0  = s_to_m0_data_o; s_d1  = s_to_m1_data_o;
      if (!rst_n) begin
         chk("rst_cyc", s_cyc, 0);       chk("rst_stb", s_stb, 0);
         chk("rst_we", s_we, 0);         chk("rst_addr", s_addr, 0);
         chk("rst_sel", s_sel, 0);       chk("rst_dat", s_dat, 0);
         chk("rst_hrden0", s_hr0, 0);    chk("rst_hrden1", s_hr1, 0);
         chk("rst_drden0", m0_to_s_drden, 0); chk("rst_drden1", m1_to_s_drden, 0);
         chk("rst_dempty0", s_de0, 1);   chk("rst_dempty1", s_de1, 1);
         model_reset();
      end else begin
         chk("hrden_onehot", s_hr0 && s_hr1, 0);
         if (s_hr0) begin
            chk("pop0_nonempty", hq0.size() != 0, 1);
            chk("pop0_credit", cred0 > 0, 1);
            if (hq0.size() != 0) chk("drden0_we", m0_to_s_drden, hq0[0].we);
         end else chk("drden0_idle", m0_to_s_drden, 0);
         if (s_hr1) begin
            chk("pop1_nonempty", hq1.size() != 0, 1);
            chk("pop1_credit", cred1 > 0, 1);
            if (hq1.size() != 0) chk("drden1_we", m1_to_s_drden, hq1[0].we);
         end else chk("drden1_idle", m1_to_s_drden, 0);
         if (pend && s_wb_stall_o) chk("pop_in_stall", s_hr0 || s_hr1, 0);
         if ((s_hr0 || s_hr1) && hq0.size() != 0 && hq1.size() != 0 && cred0 > 0 && cred1 > 0)
            chk("arb_winner", s_hr1, m1_is_older(hq0[0].tag, hq1[0].tag));
         chk("stb", s_stb, pend);
         if (pend) begin
            chk("bus_addr", s_addr, preq.addr);
            chk("bus_sel", s_sel, preq.sel);
            chk("bus_we", s_we, preq.we);
            if (preq.we) chk("bus_wdat", s_dat, preq.data);
         end
         chk("cyc", s_cyc, pend || (oq.size() != 0));
         chk("dempty0", s_de0, rq0.size() == 0);
         if (rq0.size() != 0) chk("rdat0", s_d0, rq0[0]);
         chk("dempty1", s_de1, rq1.size() == 0);
         if (rq1.size() != 0) chk("rdat1", s_d1, rq1[0]);

         if ((s_wb_ack_o || s_wb_err_o) && oq.size() != 0) begin
            id = oq.pop_front();
            v  = s_wb_err_o ? 32'h0 : s_wb_dat_o;
            if (id == 1) rq1.push_back(v);
            else         rq0.push_back(v);
         end
         if (pend && !s_wb_stall_o) begin
            oq.push_back(pid);
            acc_log.push_back('{pid, preq.addr});
            acc_cyc = cyc_no;
            pend = 1'b0;
         end
         if (s_to_m0_drden && rq0.size() != 0) begin void'(rq0.pop_front()); cred0++; end
         if (s_to_m1_drden && rq1.size() != 0) begin void'(rq1.pop_front()); cred1++; end
         if (s_hr0 && hq0.size() != 0) begin
            h = hq0.pop_front(); preq = h; pid = 0; pend = 1'b1; cred0--; pop_cyc = cyc_no;
         end else if (s_hr1 && hq1.size() != 0) begin
            h = hq1.pop_front(); preq = h; pid = 1; pend = 1'b1; cred1--; pop_cyc = cyc_no;
         end
      end
      @(posedge clk);
      #1;
      drive_hdr();
   endtask

   task automatic run_until_acc(input int n, input int budget);
      for (int i = 0; i < budget && acc_log.size() < n; i++) cycle();
      chk("accept_timeout", acc_log.size() >= n, 1);
   endtask

   task automatic ack_one(input logic [31:0] dat, input logic is_err);
      s_wb_dat_o = dat;
      s_wb_ack_o = !is_err;
      s_wb_err_o = is_err;
      cycle();
      s_wb_ack_o = 1'b0;
      s_wb_err_o = 1'b0;
      s_wb_dat_o = '0;
   endtask

   task automatic drain();
      for (int i = 0; i < 12 && (rq0.size() != 0 || rq1.size() != 0); i++) begin
         s_to_m0_drden = (rq0.size() != 0);
         s_to_m1_drden = (rq1.size() != 0);
         cycle();
      end
      s_to_m0_drden = 1'b0;
      s_to_m1_drden = 1'b0;
      chk("drain_done", (rq0.size() == 0) && (rq1.size() == 0), 1);
   endtask

   initial begin
      s_wb_dat_o = '0; s_wb_ack_o = 1'b0; s_wb_err_o = 1'b0; s_wb_stall_o = 1'b0;
      s_to_m0_drden = 1'b0; s_to_m1_drden = 1'b0;
      cyc_no = 0; pop_cyc = 0; acc_cyc = 0; pid = 0;
      preq = '{default: '0};
      model_reset();
      drive_hdr();

      // Reset with a header already waiting: it must not be popped until reset is released.
      rst_n = 1'b0;
      push_hdr(0, 32'h10, 4'hF, 1'b0, 4'd3, 32'h0);
      repeat (3) cycle();
      rst_n = 1'b1;

      // Single read
      run_until_acc(1, 10);
      chk("read_pop_to_stb", acc_cyc - pop_cyc, 1);
      chk("read_addr", acc_addr(0), 32'h10);
      chk("read_id", acc_id(0), 0);
      ack_one(32'hDEAD_BEEF, 1'b0);
      cycle();
      chk("read_rsp_present", s_de0, 0);
      chk("read_rsp_data", s_d0, 32'hDEAD_BEEF);
      chk("read_cyc_drop", s_cyc, 0);
      drain();

      // Arbitration: older tag first, including wrap-around
      acc_log.delete();
      push_hdr(0, 32'h50, 4'hF, 1'b0, 4'd5, 32'h0);
      push_hdr(1, 32'h20, 4'hF, 1'b0, 4'd2, 32'h0);
      run_until_acc(2, 10);
      chk("arb_first_m1", acc_id(0), 1);
      chk("arb_first_addr", acc_addr(0), 32'h20);
      chk("arb_second_m0", acc_id(1), 0);
      ack_one(32'h1111_0001, 1'b0);
      ack_one(32'h1111_0002, 1'b0);
      drain();
      acc_log.delete();
      push_hdr(0, 32'hF0, 4'hF, 1'b0, 4'd15, 32'h0);
      push_hdr(1, 32'h01, 4'hF, 1'b0, 4'd1, 32'h0);
      run_until_acc(2, 10);
      chk("arb_wrap_first_m0", acc_id(0), 0);
      chk("arb_wrap_second_m1", acc_id(1), 1);
      ack_one(32'h2222_0001, 1'b0);
      ack_one(32'h2222_0002, 1'b0);
      drain();

      // Stall holds the request and blocks further pops
      acc_log.delete();
      s_wb_stall_o = 1'b1;
      push_hdr(0, 32'h30, 4'h3, 1'b1, 4'd6, 32'hCAFE_0001);
      push_hdr(1, 32'h34, 4'hF, 1'b0, 4'd7, 32'h0);
      for (int i = 0; i < 10 && !s_stb; i++) cycle();
      chk("stall_stb_seen", s_stb, 1);
      chk("stall_addr", s_addr, 32'h30);
      chk("stall_sel", s_sel, 4'h3);
      chk("stall_we", s_we, 1);
      chk("stall_wdat", s_dat, 32'hCAFE_0001);
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("stall_hold_addr", s_addr, 32'h30);
         chk("stall_hold_sel", s_sel, 4'h3);
         chk("stall_hold_we", s_we, 1);
         chk("stall_hold_dat", s_dat, 32'hCAFE_0001);
         chk("stall_no_hrden", s_hr0 || s_hr1, 0);
      end
      s_wb_stall_o = 1'b0;
      run_until_acc(2, 10);
      chk("stall_after_m1", acc_id(1), 1);
      ack_one(32'h1234_5678, 1'b0);
      ack_one(32'h3333_4444, 1'b0);
      drain();

      // Credits: four outstanding m0 reads exhaust m0's credit
      acc_log.delete();
      for (int i = 0; i < 5; i++) push_hdr(0, 32'h100 + 32'(4*i), 4'hF, 1'b0, 4'(i), 32'h0);
      run_until_acc(4, 12);
      for (int i = 0; i < 4; i++) ack_one(32'h4000 + 32'(i), 1'b0);
      for (int i = 0; i < 4; i++) begin
         cycle();
         chk("credit_blocked", s_hr0, 0);
      end
      chk("credit_count4", acc_log.size(), 4);
      s_to_m0_drden = 1'b1;
      cycle();
      s_to_m0_drden = 1'b0;
      run_until_acc(5, 10);
      chk("credit_fifth_addr", acc_addr(4), 32'h110);
      ack_one(32'h4004, 1'b0);
      drain();

      // Interleaved m0/m1/m0 with an error on the second
      acc_log.delete();
      push_hdr(0, 32'h200, 4'hF, 1'b0, 4'd6, 32'h0);
      push_hdr(1, 32'h204, 4'hF, 1'b0, 4'd7, 32'h0);
      push_hdr(0, 32'h208, 4'hF, 1'b0, 4'd8, 32'h0);
      run_until_acc(3, 10);
      chk("ilv_id0", acc_id(0), 0);
      chk("ilv_id1", acc_id(1), 1);
      chk("ilv_id2", acc_id(2), 0);
      ack_one(32'hA0A0_A0A0, 1'b0);
      ack_one(32'hBADB_AD00, 1'b1);
      ack_one(32'hA2A2_A2A2, 1'b0);
      cycle();
      chk("ilv_err_present", s_de1, 0);
      chk("ilv_err_zero", s_d1, 32'h0);
      chk("ilv_m0_head", s_d0, 32'hA0A0_A0A0);
      drain();

      // Reset mid-burst with three requests outstanding and one response queued
      acc_log.delete();
      push_hdr(0, 32'h300, 4'hF, 1'b0, 4'd9,  32'h0);
      push_hdr(1, 32'h304, 4'hF, 1'b0, 4'd10, 32'h0);
      push_hdr(0, 32'h308, 4'hF, 1'b0, 4'd11, 32'h0);
      push_hdr(1, 32'h30C, 4'hF, 1'b0, 4'd12, 32'h0);
      run_until_acc(4, 12);
      chk("burst_order", {acc_id(0) == 0, acc_id(1) == 1, acc_id(2) == 0, acc_id(3) == 1}, 4'b1111);
      ack_one(32'h600D_0001, 1'b0);
      cycle();
      chk("burst_rsp_queued", s_de0, 0);
      rst_n = 1'b0;
      repeat (2) cycle();
      chk("burst_rst_cyc", s_cyc, 0);
      chk("burst_rst_dempty0", s_de0, 1);
      chk("burst_rst_dempty1", s_de1, 1);
      rst_n = 1'b1;
      s_wb_dat_o = 32'h0BAD_0BAD;
      s_wb_ack_o = 1'b1;
      repeat (3) cycle();
      s_wb_ack_o = 1'b0;
      cycle();
      chk("late_ack_dempty0", s_de0, 1);
      chk("late_ack_dempty1", s_de1, 1);
      chk("late_ack_cyc", s_cyc, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Global bound so the run always ends.
   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not reach the end of the sequence");
      $fatal(1, "timeout");
   end

endmodule
